ram_sp_requester: RTL and testbench

//  Initiator side of the single-port RAM interface (we/addr/data_in, data_out one cycle after addr).

---
 rtl/ram_sp_requester_pkg.sv | 13 +
 rtl/ram_sp_requester_rsp_fifo2.sv | 66 ++++++
 rtl/ram_sp_requester.sv | 116 +++++++++++
 tb/tb_ram_sp_requester.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_requester_pkg.sv
// Shared definitions for the single-port RAM requester: grant encoding and
// response FIFO sizing.
package ram_sp_requester_pkg;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_sp_requester_rsp_fifo2.sv
// rsp_fifo2: 2-entry synchronous FIFO with valid/ready on both sides and an
// occupancy count. The head entry is a register, so out_valid/out_data come
// straight from flops.
//   clk, rst            clock, synchronous active-high reset (clears occupancy)
//   in_valid/in_ready   push side; a push is taken whenever in_valid is high
//   in_data             push data
//   out_valid/out_ready pop side
//   out_data            head entry
//   count               number of entries held (0..2)
module rsp_fifo2
  import ram_sp_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RSP_CNT_W-1:0]  count
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [RSP_CNT_W-1:0]  count_q;
  logic                  push;
  logic                  pop;

  assign push      = in_valid;
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count_q != RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + RSP_CNT_W'(1);
    end else if (pop && !push) begin
      count_q <= count_q - RSP_CNT_W'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (count_q == RSP_CNT_W'(1)) begin
        head_q <= in_data;
      end else begin
        head_q <= tail_q;
        tail_q <= in_data;
      end
    end else if (pop) begin
      head_q <= tail_q;
    end else if (push) begin
      if (count_q == '0) head_q <= in_data;
      else               tail_q <= in_data;
    end
  end

endmodule

// File: rtl/ram_sp_requester.sv
// ram_sp_requester: merges a write-request stream and a read-request stream
// onto one single-port RAM (data_out valid the cycle after the address) and
// returns read data in request order through a valid/ready response stream.
//   clk, rst                    clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data   write requests
//   rd_valid/rd_ready/rd_addr           read requests
//   rsp_valid/rsp_ready/rsp_data        read responses (backpressured)
//   ram_we/ram_addr/ram_data_in/ram_data_out  RAM port
//   wr_cnt/rd_cnt               issued-operation counters, wrapping
module ram_sp_requester
  import ram_sp_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  grant_e                last_grant;
  logic                  gnt_wr;
  logic                  gnt_rd;
  logic                  rd_elig;
  logic                  rd_pend;
  logic                  fifo_in_ready;
  logic                  fifo_pop;
  logic [RSP_CNT_W-1:0]  fifo_count;
  logic [RSP_CNT_W:0]    credit_used;
  logic [ADDR_WIDTH-1:0] addr_hold_p1;

  assign fifo_pop = rsp_valid && rsp_ready;

  // Credit covers entries already queued plus the read still in flight. An
  // entry leaving this cycle frees its slot immediately, which is what lets
  // back-to-back reads stream at one response per cycle.
  always_comb begin
    credit_used = {1'b0, fifo_count} + (RSP_CNT_W+1)'(rd_pend) - (RSP_CNT_W+1)'(fifo_pop);
    rd_elig     = rd_valid && (credit_used < (RSP_CNT_W+1)'(RSP_FIFO_DEPTH));
    gnt_wr      = 1'b0;
    gnt_rd      = 1'b0;
    if (!rst) begin
      if (wr_valid && rd_elig) begin
        if (last_grant == GRANT_RD) gnt_wr = 1'b1;
        else                        gnt_rd = 1'b1;
      end else if (wr_valid) begin
        gnt_wr = 1'b1;
      end else if (rd_elig) begin
        gnt_rd = 1'b1;
      end
    end
  end

  assign wr_ready    = gnt_wr;
  assign rd_ready    = gnt_rd;
  assign ram_we      = gnt_wr;
  assign ram_data_in = wr_data;
  assign ram_addr    = gnt_wr ? wr_addr : (gnt_rd ? rd_addr : addr_hold_p1);

  // Issue stage -> capture stage: rd_pend marks the cycle ram_data_out is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_RD;
      rd_pend    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      rd_pend <= gnt_rd;
      if (gnt_wr) begin
        last_grant <= GRANT_WR;
        wr_cnt     <= wr_cnt + CNT_WIDTH'(1);
      end
      if (gnt_rd) begin
        last_grant <= GRANT_RD;
        rd_cnt     <= rd_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_hold_p1 <= ram_addr;
  end

  // Capture stage -> response stage.
  rsp_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend),
    .in_ready  (fifo_in_ready),
    .in_data   (ram_data_out),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (rsp_data),
    .count     (fifo_count)
  );

  a_one_grant: assert property (@(posedge clk) !(gnt_wr && gnt_rd));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) rd_pend |-> fifo_in_ready);

endmodule

// File: tb/tb_ram_sp_requester.sv
module tb_ram_sp_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, rd_valid, rd_ready;
  logic [4:0] wr_addr, rd_addr, ram_addr;
  logic [7:0] wr_data, rsp_data, ram_data_in, ram_data_out;
  logic       rsp_valid, rsp_ready, ram_we;
  logic [31:0] wr_cnt, rd_cnt;

  logic [7:0] mem [0:31];
  logic [7:0] rd_exp;
  logic [7:0] exp_q [$];
  logic       glog [$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  ram_sp_requester dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  // Single-port RAM, read-first, data_out one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake; records
  // accepted requests (pushing the expected read data) and the grant order.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
        end else begin
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (rd_valid && rd_ready) begin
        exp_q.push_back(rd_exp);
        glog.push_back(1'b1);
      end
      if (wr_valid && wr_ready) glog.push_back(1'b0);
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wr_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] e);
    bit ok = 1'b0;
    rd_valid = 1'b1; rd_addr = a; rd_exp = e;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Reads are accepted at the edge ending cycle N; the caller sits in N+1.
  task automatic check_latency(input string tag, input logic [7:0] e);
    @(negedge clk);
    chk({tag, "_rsp_valid_n1"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_valid_n2"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_data_n2"}, {24'd0, rsp_data}, {24'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic [7:0]  gv;
    rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
    wr_addr = 5'd0; wr_data = 8'd0; rd_addr = 5'd0; rd_exp = 8'd0;

    // T1 reset with both valids high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("t1_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_ram_we", {31'd0, ram_we}, 32'd0);
    chk("t1_wr_cnt", wr_cnt, 32'd0);
    chk("t1_rd_cnt", rd_cnt, 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_valid = 1'b0; rst = 1'b0;

    // T2 write 0xA5 to 3, read it back with two-cycle latency
    do_write(5'd3, 8'hA5);
    do_read(5'd3, 8'hA5);
    check_latency("t2", 8'hA5);
    chk("t2_wr_cnt", wr_cnt, 32'd1);
    chk("t2_rd_cnt", rd_cnt, 32'd1);
    drain();

    // T3 both streams valid for 8 cycles: grants alternate starting with WR
    glog.delete();
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 8'h5A;
    rd_valid = 1'b1; rd_addr = 5'd3;  rd_exp = 8'hA5;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    drain();
    chk("t3_grant_count", glog.size(), 32'd8);
    gv = 8'd0;
    for (int i = 0; i < 8 && i < glog.size(); i++) gv[i] = glog[i];
    chk("t3_grant_order", {24'd0, gv}, 32'h000000AA);
    chk("t3_wr_cnt", wr_cnt, 32'd5);
    chk("t3_rd_cnt", rd_cnt, 32'd5);

    // T4 backpressure: only two reads may be in the FIFO/in flight
    for (int i = 0; i < 5; i++) do_write(5'(20 + i), 8'(8'h30 + i));
    drain();
    base = rd_cnt;
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) do_read(5'(20 + i), 8'(8'h30 + i));
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t4_rd_ready_blocked", {31'd0, rd_ready}, 32'd0);
        chk("t4_rd_accepted", rd_cnt - base, 32'd2);
        chk("t4_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
        chk("t4_rsp_data_held", {24'd0, rsp_data}, 32'h30);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("t4_rd_total", rd_cnt - base, 32'd5);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // T5 read-then-write returns old data; later read sees new data
    do_write(5'd7, 8'h11);
    do_read(5'd7, 8'h11);
    do_write(5'd7, 8'h22);
    do_read(5'd7, 8'h22);
    drain();
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // T6 reset the cycle after a read issue discards it
    do_read(5'd3, 8'hA5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    chk("t6_wr_cnt", wr_cnt, 32'd0);
    chk("t6_rd_cnt", rd_cnt, 32'd0);
    @(posedge clk); #1;
    do_read(5'd3, 8'hA5);
    check_latency("t6", 8'hA5);
    chk("t6_rd_cnt_after", rd_cnt, 32'd1);
    drain();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
